// File: rtl/run_controller.sv
// Run controller: starts the CPU, counts RUN cycles, stops on END_PC or cycle limit and
// captures a window of writeback registers. Optional PC-stall stop via RUN_CTRL_STALL_DETECT_EN.
module run_controller #(
  parameter int PC_W         = 32,
  parameter int CYC_W        = 32,
  parameter int MAX_CYCLES   = 3000,
  parameter int END_PC       = 424,
  parameter int NUM_WATCH    = 2,
  parameter int WATCH_BASE   = 18,
  parameter int STALL_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_W-1:0]        pc,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   stalled,
  output logic [CYC_W-1:0]       cycles,
  output logic [PC_W-1:0]        end_pc,
  output logic [32*NUM_WATCH-1:0] watch_data,
  output logic [NUM_WATCH-1:0]   watch_valid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [PC_W-1:0]  L_END_PC   = PC_W'(END_PC);
  localparam logic [CYC_W-1:0] L_LAST_CYC = CYC_W'(MAX_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic                         r_done;
  logic                         r_timeout;
  logic [CYC_W-1:0]             r_cycles;
  logic [PC_W-1:0]              r_end_pc;
  logic [NUM_WATCH-1:0][31:0]   r_watch_data;
  logic [NUM_WATCH-1:0]         r_watch_valid;

  logic                         w_run;
  logic                         w_clear;
  logic                         w_end_hit;
  logic                         w_limit_hit;
  logic                         w_stall_hit;
  logic [NUM_WATCH-1:0]         w_hit;

  assign w_run       = (r_state == S_RUN);
  assign w_clear     = (w_state_next == S_ARM);
  assign w_end_hit   = (pc == L_END_PC);
  assign w_limit_hit = (r_cycles == L_LAST_CYC);

`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam int SC_W = $clog2(STALL_CYCLES) + 1;

  logic [PC_W-1:0] r_prev_pc;
  logic            r_first;
  logic [SC_W-1:0] r_stall_cnt;
  logic            r_stalled;
  logic            w_pc_same;

  // The counter counts repeats of the previous PC; the cycle that would push it
  // to STALL_CYCLES-1 is the terminating one.
  assign w_pc_same   = w_run && !r_first && (pc == r_prev_pc);
  assign w_stall_hit = w_pc_same && (r_stall_cnt == SC_W'(STALL_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_prev_pc   <= '0;
      r_first     <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_prev_pc   <= pc;
      r_first     <= 1'b0;
      r_stall_cnt <= w_pc_same ? r_stall_cnt + SC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_stalled <= 1'b0;
    end else if (w_run && !w_end_hit && w_stall_hit) begin
      r_stalled <= 1'b1;
    end
  end

  assign stalled = r_stalled;
`else
  assign w_stall_hit = 1'b0;
  assign stalled     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_ARM;
      S_ARM:     w_state_next = S_RUN;
      S_RUN: begin
        if (w_end_hit || w_stall_hit) begin
          w_state_next = S_DONE;
        end else if (w_limit_hit) begin
          w_state_next = S_TIMEOUT;
        end
      end
      S_DONE,
      S_TIMEOUT: if (start) w_state_next = S_ARM;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Results are wiped on the edge that enters ARM, so ARM itself already shows zeros.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
      r_end_pc  <= '0;
    end else if (w_run) begin
      r_cycles <= r_cycles + CYC_W'(1);
      if (w_end_hit || w_stall_hit) begin
        r_done   <= 1'b1;
        r_end_pc <= pc;
      end else if (w_limit_hit) begin
        r_timeout <= 1'b1;
        r_end_pc  <= pc;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WATCH; gi++) begin : g_slot
      localparam int REG_NUM = WATCH_BASE + gi;
      assign w_hit[gi] = w_run && wb_en && (REG_NUM != 0) && (wb_addr == 5'(REG_NUM));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_watch_data  <= '0;
      r_watch_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (w_hit[i]) begin
          r_watch_data[i]  <= wb_data;
          r_watch_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign cpu_rst     = (r_state != S_RUN);
  assign busy        = (r_state == S_ARM) || (r_state == S_RUN);
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycles      = r_cycles;
  assign end_pc      = r_end_pc;
  assign watch_data  = r_watch_data;
  assign watch_valid = r_watch_valid;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed runs plus random runs checked against a per-cycle
// scan model of the termination and capture rules.
module tb_run_controller;
  localparam int TB_MAX = 200;
  localparam int TB_END = 424;
  localparam int TB_NW  = 2;
  localparam int TB_WB  = 18;
  localparam int TB_SC  = 8;
`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cpu_rst, busy, done, timeout, stalled;
  logic [31:0] cycles;
  logic [31:0] end_pc;
  logic [63:0] watch_data;
  logic [1:0]  watch_valid;

  run_controller #(
    .PC_W(32), .CYC_W(32), .MAX_CYCLES(TB_MAX), .END_PC(TB_END),
    .NUM_WATCH(TB_NW), .WATCH_BASE(TB_WB), .STALL_CYCLES(TB_SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .timeout(timeout),
    .stalled(stalled), .cycles(cycles), .end_pc(end_pc),
    .watch_data(watch_data), .watch_valid(watch_valid)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] pcs [256];
  bit          wbe [256];
  logic [4:0]  wba [256];
  logic [31:0] wbd [256];
  int          start_at;

  logic        exp_done, exp_timeout, exp_stalled;
  logic [31:0] exp_cycles, exp_end_pc;
  logic [63:0] exp_wdata;
  logic [1:0]  exp_wvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_base();
    for (int k = 0; k < 256; k++) begin
      pcs[k] = 32'(1000 + 4 * k);
      wbe[k] = 1'b0;
      wba[k] = 5'd0;
      wbd[k] = 32'd0;
    end
    start_at = -1;
  endtask

  // Walk the program cycle by cycle: capture first, then termination priority
  // end-PC > stall (PC unchanged for TB_SC consecutive cycles) > cycle limit.
  task automatic model();
    int  run_len;
    int  slot;
    bit  ended;
    run_len     = 0;
    ended       = 1'b0;
    exp_done    = 1'b0;
    exp_timeout = 1'b0;
    exp_stalled = 1'b0;
    exp_cycles  = 32'd0;
    exp_end_pc  = 32'd0;
    exp_wdata   = 64'd0;
    exp_wvalid  = 2'b00;
    for (int k = 0; k < TB_MAX && !ended; k++) begin
      run_len = (k > 0 && pcs[k] == pcs[k-1]) ? run_len + 1 : 1;
      if (wbe[k] && int'(wba[k]) >= TB_WB && int'(wba[k]) < TB_WB + TB_NW && wba[k] != 5'd0) begin
        slot = int'(wba[k]) - TB_WB;
        exp_wdata[32*slot +: 32] = wbd[k];
        exp_wvalid[slot] = 1'b1;
      end
      if (pcs[k] == 32'(TB_END)) begin
        exp_done = 1'b1; ended = 1'b1;
      end else if (STALL_ON && run_len >= TB_SC) begin
        exp_done = 1'b1; exp_stalled = 1'b1; ended = 1'b1;
      end else if (k == TB_MAX - 1) begin
        exp_timeout = 1'b1; ended = 1'b1;
      end
      if (ended) begin
        exp_cycles = 32'(k + 1);
        exp_end_pc = pcs[k];
      end
    end
  endtask

  task automatic check_result(input string name);
    check({name, "_done"},    done,        exp_done);
    check({name, "_timeout"}, timeout,     exp_timeout);
    check({name, "_stalled"}, stalled,     exp_stalled);
    check({name, "_cycles"},  cycles,      exp_cycles);
    check({name, "_end_pc"},  end_pc,      exp_end_pc);
    check({name, "_wdata"},   watch_data,  exp_wdata);
    check({name, "_wvalid"},  watch_valid, exp_wvalid);
    check({name, "_busy"},    busy,        1'b0);
    check({name, "_cpu_rst"}, cpu_rst,     1'b1);
  endtask

  task automatic run_program(input string name);
    int k;
    model();
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_arm_cpu_rst"}, cpu_rst, 1'b1);
    check({name, "_arm_busy"},    busy,    1'b1);
    check({name, "_arm_clear"},   {done, timeout, stalled, cycles, watch_valid}, '0);
    step();
    k = 0;
    while (k < TB_MAX + 5) begin
      pc      = pcs[k];
      wb_en   = wbe[k];
      wb_addr = wba[k];
      wb_data = wbd[k];
      start   = (k == start_at);
      if (k == 0) check({name, "_run_cpu_rst"}, cpu_rst, 1'b0);
      step();
      if (!busy) break;
      k++;
    end
    start = 1'b0;
    wb_en = 1'b0;
    check({name, "_terminated"}, busy, 1'b0);
    check_result(name);
    // Writeback and PC activity after the run must not disturb the held results.
    for (int j = 0; j < 3; j++) begin
      pc      = 32'(TB_END);
      wb_en   = 1'b1;
      wb_addr = 5'(TB_WB);
      wb_data = $urandom;
      step();
    end
    wb_en = 1'b0;
    check_result({name, "_hold"});
    $display("run %s: cycles=%0d done=%0b timeout=%0b stalled=%0b", name, cycles, done, timeout, stalled);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; pc = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    start_at = -1;
    repeat (3) step();
    check("rst_start_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_outputs", {busy, done, timeout, stalled, cycles, end_pc, watch_data, watch_valid}, '0);
    step();
    check("idle_busy", busy, 1'b0);

    fill_base();
    pcs[99] = 32'(TB_END);
    run_program("endpc");
    check("endpc_cycles100", cycles, 32'd100);

    fill_base();
    run_program("timeout");
    check("timeout_cycles", cycles, 32'(TB_MAX));

    fill_base();
    pcs[TB_MAX-1] = 32'(TB_END);
    run_program("endpc_last");

    fill_base();
    pcs[0] = 32'(TB_END);
    run_program("endpc_first");

    fill_base();
    pcs[60] = 32'(TB_END);
    wbe[5]  = 1'b1; wba[5]  = 5'd18; wbd[5]  = 32'd1973;
    wbe[10] = 1'b1; wba[10] = 5'd18; wbd[10] = 32'd1979;
    wbe[12] = 1'b1; wba[12] = 5'd19; wbd[12] = 32'd2003;
    wbe[14] = 1'b1; wba[14] = 5'd17; wbd[14] = 32'd5;
    run_program("capture");
    check("capture_slots", watch_data, {32'd2003, 32'd1979});

    fill_base();
    pcs[40]  = 32'(TB_END);
    start_at = 20;
    run_program("restart1");
    fill_base();
    pcs[30] = 32'(TB_END);
    run_program("restart2");
    check("restart2_cycles", cycles, 32'd31);

    fill_base();
    for (int k = 10; k < 256; k++) pcs[k] = 32'd100;
    run_program("stall");
    check("stall_cycles", cycles, STALL_ON ? 32'd18 : 32'(TB_MAX));

    for (int r = 0; r < 20; r++) begin
      int mode;
      int at;
      fill_base();
      mode = int'($urandom_range(0, 2));
      at   = int'($urandom_range(0, TB_MAX - 1));
      for (int k = 0; k < 256; k++) begin
        wbe[k] = 1'($urandom_range(0, 1));
        wba[k] = 5'($urandom_range(16, 21));
        wbd[k] = $urandom;
      end
      if (mode == 0) pcs[at] = 32'(TB_END);
      if (mode == 1) for (int k = at; k < 256; k++) pcs[k] = 32'd3000;
      start_at = int'($urandom_range(0, TB_MAX));
      run_program($sformatf("rand%0d_m%0d", r, mode));
    end

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    pc = 32'd1000; wb_en = 1'b1; wb_addr = 5'd18; wb_data = 32'd77;
    step();
    step();
    check("midrun_captured", watch_valid, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_cpu_rst", cpu_rst, 1'b1);
    check("midrun_rst_outputs", {busy, done, timeout, stalled, cycles, end_pc, watch_data, watch_valid}, '0);
    step();
    wb_en = 1'b0;
    check("midrun_idle_capture", {busy, watch_valid}, '0);
    $display("midrun reset: busy=%0b watch_valid=%0b", busy, watch_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run controller for the pipelined CPU. Replaces the fixed cycle-count `$finish` loop of the CPU testbenches with hardware that starts a program, counts cycles and stops the CPU on one of two events: the fetch PC reaching a programmed end address, or a configurable cycle limit expiring. While the program runs it snoops the register-file writeback port and captures a parametrised window of result registers. It sits beside `CPU`, drives the CPU reset, and is used both in simulation benches and on the FPGA board flow.

## Interface
Parameters:
- `PC_W`, 32, width of the PC and of `end_pc`.
- `CYC_W`, 32, width of the cycle counter.
- `MAX_CYCLES`, 3000, cycle limit. Legal range 1..2^CYC_W-1.
- `END_PC`, 424, byte address whose fetch ends the run (instruction 106).
- `NUM_WATCH`, 2, number of captured registers. Legal range 1..8.
- `WATCH_BASE`, 18, first captured register number. `WATCH_BASE+NUM_WATCH` must be ≤ 32.
- `STALL_CYCLES`, 8, PC-stall threshold. Only used with `RUN_CTRL_STALL_DETECT_EN`. Legal range ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin or restart a run.
- `pc` in `PC_W`: CPU fetch PC, byte address.
- `wb_en` in 1: register-file write enable.
- `wb_addr` in 5: register-file write address.
- `wb_data` in 32: register-file write data.
- `cpu_rst` out 1: reset to `CPU`. High in every state except RUN.
- `busy` out 1: high in ARM and RUN.
- `done` out 1: run ended at `END_PC` or by stall.
- `timeout` out 1: run ended at the cycle limit.
- `stalled` out 1: run ended by stall detection.
- `cycles` out `CYC_W`: RUN cycles elapsed.
- `end_pc` out `PC_W`: `pc` sampled in the terminating cycle.
- `watch_data` out `32*NUM_WATCH`: captured values. Slot i is `[32*i+31:32*i]` and holds register `WATCH_BASE+i`.
- `watch_valid` out `NUM_WATCH`: bit i is set once slot i has been written.

## Operation
States:
- IDLE
  - `start` → ARM.
- ARM (exactly one cycle)
  - `cpu_rst`=1.
  - Clears `cycles`, `watch_data`, `watch_valid`, `end_pc`, `done`, `timeout`, `stalled` and the stall counter.
  - Always → RUN.
- RUN
  - `cpu_rst`=0.
  - `cycles` increments by 1 every cycle.
  - Termination is evaluated on the current cycle's inputs, with this priority:
    1. `pc==END_PC` → DONE.
    2. Stall detection fires → DONE with `stalled`=1.
    3. `cycles==MAX_CYCLES-1` → TIMEOUT.
  - `start` is ignored in RUN.
- DONE / TIMEOUT
  - `cpu_rst`=1, which freezes the CPU.
  - All outputs hold their values.
  - `start` → ARM (restart).

Capture:
- Active only in RUN, including the terminating cycle.
- Condition: `wb_en` and `WATCH_BASE ≤ wb_addr < WATCH_BASE+NUM_WATCH`.
- Action: the matching slot ← `wb_data` and its `watch_valid` bit is set. A later write to the same register overwrites the slot.
- Writes to register 0 are never captured, even when `WATCH_BASE`=0.
- Writeback activity outside RUN is ignored.

Arithmetic:
- `cycles` never wraps, because TIMEOUT caps it at `MAX_CYCLES`.
- The PC compare is a full `PC_W`-bit equality.

## Timing
Reset values:
- State IDLE.
- `cpu_rst`=1.
- All other outputs 0: `busy`, `done`, `timeout`, `stalled`, `cycles`, `end_pc`, `watch_data`, `watch_valid`.

Start sequence:
- `start` is sampled at edge t.
- ARM occupies cycle t+1.
- RUN begins at cycle t+2. `cpu_rst` falls at edge t+1→t+2.

Termination:
- If the terminating condition is seen in RUN cycle k, counted from 0, then after the next edge:
  - `cycles`=k+1.
  - `done` or `timeout` = 1.
  - `busy`=0 and `cpu_rst`=1.
- Result is 1 cycle after the event. All outputs are registered.

Timeout:
- Taken after exactly `MAX_CYCLES` RUN cycles, leaving `cycles`=`MAX_CYCLES`.

Simultaneous events:
- `END_PC` in the last allowed cycle → DONE, not TIMEOUT.
- `start` together with `rst` → `rst` wins, state is IDLE.

Reset mid-run:
- `rst` in any state returns to IDLE on the next edge.
- All outputs return to reset values and the capture is lost.

## Configuration
`RUN_CTRL_STALL_DETECT_EN` defined:
- The controller tracks the previous-cycle PC.
- Counter rules:
  - First RUN cycle: counter 0.
  - `pc` equal to the previous PC: increment.
  - Otherwise: clear.
- When the counter reaches `STALL_CYCLES-1` with `pc` still equal, that cycle terminates the run: → DONE, `stalled`=1.
- This catches self-loop halts, i.e. `j .`.

Not defined:
- No stall logic is built.
- `stalled` is tied to 0.
- The run ends only at `END_PC` or the cycle limit.

## Test plan
1. Reset: hold `rst` 3 cycles, then release → `cpu_rst`=1, all other outputs 0, state IDLE; `start` with `rst` high → still IDLE.
2. End-PC stop: `MAX_CYCLES`=3000, pulse `start`, drive `pc`=424 in RUN cycle 99 → next cycle `done`=1, `cycles`=100, `end_pc`=424, `cpu_rst`=1, `timeout`=0.
3. Timeout: `MAX_CYCLES`=50, `pc` never 424 → `timeout`=1 with `cycles`=50; `END_PC` in cycle 49 instead → `done`=1, `timeout`=0.
4. Capture: in RUN write r18=1973 then r18=1979, r19=2003, r17=5 → slot0=1979, slot1=2003, `watch_valid`=2'b11; r17 not captured; a write to r18 after DONE does not change slot0.
5. Restart: after DONE, pulse `start` → ARM clears everything and `cpu_rst` stays high 1 cycle; second run ends with fresh `cycles`; `start` during RUN has no effect.
6. Stall (macro on, `STALL_CYCLES`=8): hold `pc`=100 from RUN cycle 10 → DONE with `stalled`=1, `cycles`=18; macro off, same stimulus → TIMEOUT at `MAX_CYCLES`.
